// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared encodings and pattern constants for the LED bar sequencer
package led_seq_pkg;

    localparam int LED_W = 10;

    typedef enum logic [1:0] {
        MODE_SCAN  = 2'd0,
        MODE_FILL  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_COUNT = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic [LED_W-1:0] SCAN_INIT = 10'h003;
    localparam logic [LED_W-1:0] BLINK_A   = 10'h155;
    localparam logic [LED_W-1:0] BLINK_B   = 10'h2AA;
    localparam logic [LED_W-1:0] LED_ALL   = 10'h3FF;

    // Pattern shown when a mode is (re)loaded; FILL and COUNT start dark
    function automatic logic [LED_W-1:0] init_pattern(input mode_t m);
        return m == MODE_SCAN ? SCAN_INIT : m == MODE_BLINK ? BLINK_A : '0;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler producing the pattern step pulse at a speed-selected rate
module led_tick_gen #(
    parameter int PRESCALE_W = 18
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       run,
    input  logic [1:0] speed,
    output logic       ptick
);
    import led_seq_pkg::*;

    logic [PRESCALE_W-1:0] count;
    logic [1:0]            speed_q;
    logic                  hold;

    // A speed change restarts the period so the first pulse comes a full new period later
    assign hold  = !run || speed != speed_q;
    assign ptick = !hold && count == ({PRESCALE_W{1'b1}} >> speed);

    // Period counter, wraps to zero on each pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            count   <= '0;
            speed_q <= '0;
        end else begin
            speed_q <= speed;
            count   <= (hold || ptick) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: run/pause/step controller driving four LED bar patterns
module led_pattern_sequencer #(
    parameter int LED_W      = 10,
    parameter int PRESCALE_W = 18
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic             pause,
    input  logic             step,
    output logic [LED_W-1:0] leds,
    output logic             tick,
    output logic [1:0]       state
);
    import led_seq_pkg::*;

    localparam int               POS_W   = $clog2(LED_W);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(LED_W - 2);

    state_t           st, st_d;
    mode_t            mode_q, mode_d, mode_in;
    logic [LED_W-1:0] leds_d, adv_leds;
    logic [POS_W-1:0] pos, pos_d, adv_pos;
    logic             dir_down, dir_d, adv_dir;
    logic             drain, drain_d, adv_drain;
    logic             step_q, advance, ptick, run;

    assign mode_in = mode_t'(mode);
    assign state   = st;
    assign run     = st == ST_RUN;

    led_tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .run  (run),
        .speed(speed),
        .ptick(ptick)
    );

    // Next pattern values for one advance of the latched mode
    always_comb begin
        adv_leds  = leds;
        adv_pos   = pos;
        adv_dir   = dir_down;
        adv_drain = drain;
        case (mode_q)
            MODE_SCAN: begin
                adv_dir  = dir_down ? pos != '0 : pos == POS_MAX;
                adv_pos  = adv_dir ? pos - 1'b1 : pos + 1'b1;
                adv_leds = LED_W'(SCAN_INIT) << adv_pos;
            end
            MODE_FILL: begin
                adv_leds  = {leds[LED_W-2:0], ~drain};
                adv_drain = drain ? adv_leds != '0 : adv_leds == LED_W'(LED_ALL);
            end
            MODE_BLINK: adv_leds = leds == LED_W'(BLINK_A) ? LED_W'(BLINK_B) : LED_W'(BLINK_A);
            MODE_COUNT: adv_leds = leds + 1'b1;
        endcase
    end

    // FSM next state and pattern register inputs; disable overrides everything
    always_comb begin
        st_d    = st;
        mode_d  = mode_q;
        leds_d  = leds;
        pos_d   = pos;
        dir_d   = dir_down;
        drain_d = drain;
        advance = 1'b0;
        if (!en) begin
            st_d   = ST_IDLE;
            leds_d = '0;
        end else begin
            case (st)
                ST_IDLE: st_d = ST_LOAD;
                ST_LOAD: begin
                    st_d    = ST_RUN;
                    mode_d  = mode_in;
                    leds_d  = LED_W'(init_pattern(mode_in));
                    pos_d   = '0;
                    dir_d   = 1'b0;
                    drain_d = 1'b0;
                end
                ST_RUN, ST_PAUSE: begin
                    st_d    = mode_in != mode_q ? ST_LOAD : pause ? ST_PAUSE : ST_RUN;
                    advance = mode_in == mode_q &&
                              (run ? !pause && ptick : pause && step && !step_q);
                end
            endcase
            if (advance) begin
                leds_d  = adv_leds;
                pos_d   = adv_pos;
                dir_d   = adv_dir;
                drain_d = adv_drain;
            end
        end
    end

    // State, pattern and step-edge registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            st       <= ST_IDLE;
            mode_q   <= MODE_SCAN;
            leds     <= '0;
            tick     <= 1'b0;
            pos      <= '0;
            dir_down <= 1'b0;
            drain    <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            st       <= st_d;
            mode_q   <= mode_d;
            leds     <= leds_d;
            tick     <= advance;
            pos      <= pos_d;
            dir_down <= dir_d;
            drain    <= drain_d;
            step_q   <= step;
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed vector bench for the LED pattern sequencer
module tb_led_pattern_sequencer;

    logic       CLK = 1'b0, RST = 1'b1, en = 1'b0, pause = 1'b0, step = 1'b0;
    logic [1:0] mode = 2'd0, speed = 2'd0, state;
    logic [9:0] leds;
    logic       tick;
    int         checks = 0, failures = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [1:0] speed;
        logic       pause;
        logic       step;
        int         edges;
        logic [9:0] leds;
        logic       tick;
        logic [1:0] state;
    } vec_t;

    logic [9:0] scan_seq [16] = '{10'h006, 10'h00C, 10'h018, 10'h030, 10'h060, 10'h0C0, 10'h180, 10'h300,
                                  10'h180, 10'h0C0, 10'h060, 10'h030, 10'h018, 10'h00C, 10'h006, 10'h003};
    logic [9:0] fill_seq [21] = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F, 10'h0FF,
                                  10'h1FF, 10'h3FF, 10'h3FE, 10'h3FC, 10'h3F8, 10'h3F0, 10'h3E0, 10'h3C0,
                                  10'h380, 10'h300, 10'h200, 10'h000, 10'h001};

    led_pattern_sequencer #(.LED_W(10), .PRESCALE_W(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .en   (en),
        .mode (mode),
        .speed(speed),
        .pause(pause),
        .step (step),
        .leds (leds),
        .tick (tick),
        .state(state)
    );

    always #5 CLK = ~CLK;

    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [9:0] l, input logic t, input logic [1:0] s);
        check({name, " leds"}, 32'(leds), 32'(l));
        check({name, " tick"}, 32'(tick), 32'(t));
        check({name, " state"}, 32'(state), 32'(s));
    endtask

    task automatic wait_tick(input string name, input int exp_n, input logic [9:0] exp_leds);
        int n;
        n = 0;
        do begin
            edges(1);
            n++;
        end while (!tick && n < 40);
        check({name, " period"}, 32'(n), 32'(exp_n));
        check({name, " leds"}, 32'(leds), 32'(exp_leds));
    endtask

    initial begin
        vec_t vecs [6];
        int   ticks;
        vecs[0] = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3,  10'h000, 1'b0, 2'd0};
        vecs[1] = '{1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1,  10'h000, 1'b0, 2'd1};
        vecs[2] = '{1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1,  10'h003, 1'b0, 2'd2};
        vecs[3] = '{1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 15, 10'h003, 1'b0, 2'd2};
        vecs[4] = '{1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1,  10'h006, 1'b1, 2'd2};
        vecs[5] = '{1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1,  10'h006, 1'b0, 2'd2};
        for (int i = 0; i < 6; i++) begin
            RST = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
            speed = vecs[i].speed; pause = vecs[i].pause; step = vecs[i].step;
            edges(vecs[i].edges);
            check_out($sformatf("vec%0d", i), vecs[i].leds, vecs[i].tick, vecs[i].state);
        end
        for (int i = 1; i < 16; i++) wait_tick($sformatf("scan%0d", i), i == 1 ? 15 : 16, scan_seq[i]);

        mode = 2'd1; speed = 2'd3;
        edges(1); check_out("fill load", 10'h003, 1'b0, 2'd1);
        edges(1); check_out("fill init", 10'h000, 1'b0, 2'd2);
        for (int i = 0; i < 21; i++) wait_tick($sformatf("fill%0d", i), 2, fill_seq[i]);

        mode = 2'd3;
        edges(1); check_out("count load", 10'h001, 1'b0, 2'd1);
        edges(1); check_out("count init", 10'h000, 1'b0, 2'd2);
        for (int i = 1; i < 1024; i++) wait_tick("count", 2, 10'(i));
        wait_tick("count wrap", 2, 10'h000);
        mode = 2'd2;
        edges(1); check_out("blink load", 10'h000, 1'b0, 2'd1);
        edges(1); check_out("blink init", 10'h155, 1'b0, 2'd2);
        wait_tick("blink b", 2, 10'h2AA);
        wait_tick("blink a", 2, 10'h155);

        mode = 2'd3; speed = 2'd0;
        edges(1); check_out("p load", 10'h155, 1'b0, 2'd1);
        edges(1); check_out("p init", 10'h000, 1'b0, 2'd2);
        wait_tick("p first", 16, 10'h001);
        pause = 1'b1;
        edges(1); check_out("paused", 10'h001, 1'b0, 2'd3);
        ticks = 0;
        repeat (100) begin edges(1); ticks += int'(tick); end
        check("pause ticks", 32'(ticks), 32'd0);
        check("pause leds", 32'(leds), 32'h001);
        ticks = 0;
        repeat (3) begin
            step = 1'b1; edges(1); ticks += int'(tick);
            step = 1'b0; edges(1); ticks += int'(tick);
        end
        check("step ticks", 32'(ticks), 32'd3);
        check("step leds", 32'(leds), 32'h004);
        ticks = 0;
        step = 1'b1;
        repeat (10) begin edges(1); ticks += int'(tick); end
        step = 1'b0; edges(1); ticks += int'(tick);
        check("held step ticks", 32'(ticks), 32'd1);
        check("held step leds", 32'(leds), 32'h005);
        pause = 1'b0;
        edges(1); check_out("resume", 10'h005, 1'b0, 2'd2);
        wait_tick("resume tick", 16, 10'h006);

        en = 1'b0; mode = 2'd1;
        edges(1); check_out("disable", 10'h000, 1'b0, 2'd0);
        en = 1'b1; mode = 2'd3; speed = 2'd3;
        edges(1); check_out("re load", 10'h000, 1'b0, 2'd1);
        edges(1); check_out("re run", 10'h000, 1'b0, 2'd2);
        edges(1); check_out("pre ptick", 10'h000, 1'b0, 2'd2);
        pause = 1'b1;
        edges(1); check_out("pause on ptick", 10'h000, 1'b0, 2'd3);

        pause = 1'b0; mode = 2'd0;
        edges(1); check_out("scan reload", 10'h000, 1'b0, 2'd1);
        edges(1); check_out("scan reinit", 10'h003, 1'b0, 2'd2);
        for (int i = 0; i < 6; i++) wait_tick($sformatf("scan fast%0d", i), 2, scan_seq[i]);
        RST = 1'b1;
        edges(1); check_out("mid reset", 10'h000, 1'b0, 2'd0);
        RST = 1'b0;
        edges(1); check_out("post reset load", 10'h000, 1'b0, 2'd1);
        edges(1); check_out("post reset run", 10'h003, 1'b0, 2'd2);
        wait_tick("post reset tick", 2, 10'h006);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
